// File: rtl/ws2811_frame_ctrl.sv
// Frame sequencer for a WS2811 chain: streams a host-written pixel buffer word by
// word to the serial unit, then holds the line idle for the latch period.
module ws2811_frame_ctrl #(
  parameter int N_LEDS       = 16,
  parameter int ADDR_W       = 4,
  parameter int RESET_CYCLES = 3000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  output logic [23:0]       word,
  output logic              send_data,
  input  logic              word_sent,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        db_estado,
  output logic [ADDR_W-1:0] db_led_idx
);

  localparam int                CNT_W      = $clog2(RESET_CYCLES);
  localparam int                DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   LEDS_W     = (ADDR_W + 1)'(N_LEDS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N_LEDS - 1);
  localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_FETCH     = 3'b001,
    S_REQUEST   = 3'b010,
    S_WAIT_SENT = 3'b011,
    S_LATCH     = 3'b100,
    S_DONE      = 3'b101
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] led_idx, led_idx_nxt;
  logic [CNT_W-1:0]  latch_cnt, latch_cnt_nxt;
  logic [23:0]       word_q, word_nxt;
  logic [23:0]       pix [DEPTH];
  logic              wr_ok;

  // Entries at or above N_LEDS are never written, so they stay at zero.
  assign wr_ok = wr_en && ({1'b0, wr_addr} < LEDS_W);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pix[i] <= '0;
      end
    end else if (wr_ok) begin
      pix[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      led_idx   <= '0;
      latch_cnt <= '0;
      word_q    <= '0;
    end else begin
      state     <= state_nxt;
      led_idx   <= led_idx_nxt;
      latch_cnt <= latch_cnt_nxt;
      word_q    <= word_nxt;
    end
  end

  // Handshake: send_data is a one-cycle request issued once per word with word
  // already stable; the controller then waits for a one-cycle word_sent, which
  // is ignored in every other state.
  always_comb begin
    state_nxt     = state;
    led_idx_nxt   = led_idx;
    latch_cnt_nxt = latch_cnt;
    word_nxt      = word_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_FETCH;
          led_idx_nxt = '0;
        end
      end
      S_FETCH: begin
        // Snapshot here so host writes to the in-flight LED do not reach the wire.
        word_nxt  = pix[led_idx];
        state_nxt = S_REQUEST;
      end
      S_REQUEST: begin
        state_nxt = S_WAIT_SENT;
      end
      S_WAIT_SENT: begin
        if (word_sent) begin
          if (led_idx == LAST_IDX) begin
            state_nxt     = S_LATCH;
            latch_cnt_nxt = '0;
          end else begin
            led_idx_nxt = led_idx + 1'b1;
            state_nxt   = S_FETCH;
          end
        end
      end
      S_LATCH: begin
        if (latch_cnt == LATCH_LAST) begin
          state_nxt = S_DONE;
        end else begin
          latch_cnt_nxt = latch_cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign word       = word_q;
  assign send_data  = (state == S_REQUEST);
  assign frame_done = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign db_estado  = state;
  assign db_led_idx = led_idx;

endmodule

// File: tb/tb_ws2811_frame_ctrl.sv
// Bench for ws2811_frame_ctrl: random pixel data, a frame-level reference model
// feeding an expected-word queue, and a monitor checking words and timing.
module tb_ws2811_frame_ctrl;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int RC = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [23:0]   word;
  logic          send_data;
  logic          word_sent;
  logic          busy;
  logic          frame_done;
  logic [2:0]    db_estado;
  logic [AW-1:0] db_led_idx;
  logic          resp_ws = 1'b0;
  logic          spur_ws = 1'b0;

  assign word_sent = resp_ws | spur_ws;

  ws2811_frame_ctrl #(.N_LEDS(N), .ADDR_W(AW), .RESET_CYCLES(RC)) dut (
    .clock(clock), .reset(reset), .start(start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .word(word), .send_data(send_data),
    .word_sent(word_sent), .busy(busy), .frame_done(frame_done),
    .db_estado(db_estado), .db_led_idx(db_led_idx)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  logic [23:0] model_buf [N];
  logic [23:0] exp_q [$];
  int frame_on       = 0;
  int busy_from      = 0;
  int done_at        = -1;
  int expect_send_at = -1;
  int gen            = 0;
  int frame_sends    = 0;
  int total_sends    = 0;
  int total_done     = 0;
  int n_cmp          = 0;
  int n_bad          = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event at cycle %0d not as expected", name, cyc);
  endtask

  function automatic bit model_busy(input int c);
    return (frame_on != 0) && (c >= busy_from) && (done_at < 0 || c <= done_at);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    check("busy", busy, model_busy(cyc));
    if (send_data) begin
      check("send_cycle", cyc, expect_send_at);
      expect_send_at = -1;
      if (exp_q.size() == 0) report_fail("extra_send");
      else check("word", word, exp_q.pop_front());
      frame_sends++;
      total_sends++;
    end else if (expect_send_at >= 0 && cyc == expect_send_at) begin
      report_fail("send_missing");
    end
    if (frame_done) begin
      check("frame_done_cycle", cyc, done_at);
      total_done++;
    end else if (done_at >= 0 && cyc == done_at) begin
      report_fail("frame_done_missing");
    end
  end

  // ---------------- serial unit responder: ack 5 cycles after send ----------------
  initial begin
    int g;
    int s;
    logic [23:0] w;
    forever begin
      @(negedge clock);
      if (send_data) begin
        g = gen;
        w = word;
        s = cyc;
        repeat (5) @(posedge clock);
        #1;
        if (g == gen) begin
          resp_ws = 1'b1;
          check("word_stable", word, w);
          if (exp_q.size() > 0) expect_send_at = cyc + 2;
          else done_at = cyc + 1 + RC;
          @(posedge clock);
          #1 resp_ws = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_px(input int a, input logic [23:0] d);
    int base;
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    if (a < N) begin
      model_buf[a] = d;
      base = N - exp_q.size();
      if (a >= base) exp_q[a - base] = d;
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input bit with_ws);
    start   = 1'b1;
    spur_ws = with_ws;
    if (!model_busy(cyc)) begin
      frame_on       = 1;
      busy_from      = cyc + 1;
      done_at        = -1;
      expect_send_at = cyc + 2;
      frame_sends    = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back(model_buf[i]);
    end
    tick();
    start   = 1'b0;
    spur_ws = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((model_busy(cyc) || exp_q.size() > 0 || (frame_on != 0 && done_at < 0)) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) report_fail("timeout_idle");
    tick();
  endtask

  task automatic wait_sends(input int k);
    int n = 0;
    while (frame_sends < k && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) report_fail("timeout_sends");
  endtask

  task automatic wait_done_known();
    int n = 0;
    while (done_at < 0 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) report_fail("timeout_last_ack");
  endtask

  task automatic random_fill();
    for (int i = 0; i < N; i++) write_px(i, 24'($urandom));
  endtask

  task automatic do_reset_mid();
    reset = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_send", send_data, 1'b0);
    check("rst_word", word, 24'h0);
    check("rst_state", db_estado, 3'b000);
    check("rst_idx", db_led_idx, '0);
    check("rst_done", frame_done, 1'b0);
    gen++;
    frame_on       = 0;
    done_at        = -1;
    expect_send_at = -1;
    exp_q.delete();
    for (int i = 0; i < N; i++) model_buf[i] = '0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    int d0;
    reset   = 1'b1;
    start   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < N; i++) model_buf[i] = '0;

    @(negedge clock);
    check("init_busy", busy, 1'b0);
    check("init_send", send_data, 1'b0);
    check("init_done", frame_done, 1'b0);
    check("init_word", word, 24'h0);
    check("init_state", db_estado, 3'b000);
    check("init_idx", db_led_idx, '0);
    tick();
    reset = 1'b0;
    tick();

    // 1/2: fixed frame, out-of-range write ignored, latency checked by monitor
    write_px(0, 24'hFF0000);
    write_px(1, 24'h00FF00);
    write_px(2, 24'h0000FF);
    write_px(3, 24'h123456);
    write_px(5, 24'h777777);
    s0 = total_sends;
    d0 = total_done;
    pulse_start(1'b0);
    wait_idle();
    check("t1_sends", total_sends - s0, 4);
    check("t1_dones", total_done - d0, 1);

    // 3: starts mid-frame and during Done are ignored
    random_fill();
    s0 = total_sends;
    d0 = total_done;
    pulse_start(1'b0);
    wait_sends(2);
    repeat ($urandom_range(1, 3)) tick();
    pulse_start(1'b0);
    wait_done_known();
    while (cyc < done_at) tick();
    pulse_start(1'b0);
    wait_idle();
    check("t3_sends", total_sends - s0, 4);
    check("t3_dones", total_done - d0, 1);

    // 4: writes during WaitSent of LED 1
    write_px(0, 24'h111111);
    write_px(1, 24'h222222);
    write_px(2, 24'h333333);
    write_px(3, 24'h444444);
    pulse_start(1'b0);
    wait_sends(2);
    tick();
    write_px(1, 24'hABCDEF);
    write_px(3, 24'hABCDEF);
    write_px(5, 24'h5A5A5A);
    wait_idle();
    pulse_start(1'b0);
    wait_idle();

    // 5: reset during WaitSent of LED 2, then an all-zero frame
    random_fill();
    pulse_start(1'b0);
    wait_sends(3);
    tick();
    do_reset_mid();
    pulse_start(1'b0);
    wait_idle();

    // 6: spurious acks in Idle and Latch; start with ack together in Idle
    spur_ws = 1'b1;
    tick();
    spur_ws = 1'b0;
    #1;
    check("idle_spur_state", db_estado, 3'b000);
    tick();
    random_fill();
    pulse_start(1'b1);
    wait_done_known();
    while (cyc < done_at - 5) tick();
    spur_ws = 1'b1;
    tick();
    spur_ws = 1'b0;
    wait_idle();

    for (int f = 0; f < 2; f++) begin
      random_fill();
      pulse_start(1'($urandom_range(0, 1)));
      wait_idle();
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
